// File: rtl/scpad_sram_responder.sv
// SRAM-side scratchpad endpoint: banked read-first arrays feeding
// fixed-latency read and write-ack pipes that freeze under res_stall.
module scpad_sram_responder #(
    parameter int NUM_BANKS = 4,
    parameter int DEPTH     = 256,
    parameter int DATA_W    = 32,
    parameter int ID_W      = 2,
    parameter int READ_LAT  = 2,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        r_req_valid,
    input  logic [NUM_BANKS-1:0]        r_req_mask,
    input  logic [NUM_BANKS*AW-1:0]     r_req_addr,
    input  logic [ID_W-1:0]             r_req_id,
    input  logic                        w_req_valid,
    input  logic [NUM_BANKS-1:0]        w_req_mask,
    input  logic [NUM_BANKS*AW-1:0]     w_req_addr,
    input  logic [NUM_BANKS*DATA_W-1:0] w_req_data,
    input  logic [ID_W-1:0]             w_req_id,
    input  logic                        res_stall,
    output logic                        sram_busy,
    output logic                        r_res_valid,
    output logic [ID_W-1:0]             r_res_id,
    output logic [NUM_BANKS-1:0]        r_res_mask,
    output logic [NUM_BANKS*DATA_W-1:0] r_res_data,
    output logic                        w_res_valid,
    output logic [ID_W-1:0]             w_res_id,
    output logic [NUM_BANKS-1:0]        w_res_mask
);

    logic [DATA_W-1:0]           mem [NUM_BANKS][DEPTH];
    logic [NUM_BANKS*DATA_W-1:0] rd;

    logic [READ_LAT-1:0]         rv;
    logic [ID_W-1:0]             rid   [READ_LAT];
    logic [NUM_BANKS-1:0]        rmask [READ_LAT];
    logic [NUM_BANKS*DATA_W-1:0] rdat  [READ_LAT];
    logic [READ_LAT-1:0]         wv;
    logic [ID_W-1:0]             wid   [READ_LAT];
    logic [NUM_BANKS-1:0]        wmask [READ_LAT];

    assign sram_busy = res_stall;

    // Array read is sampled at the same edge as the write: old data wins.
    always_comb begin
        rd = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (r_req_mask[b])
                rd[b*DATA_W +: DATA_W] = mem[b][r_req_addr[b*AW +: AW]];
        end
    end

    always_ff @(posedge clk) begin
        if (!res_stall && w_req_valid) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (w_req_mask[b])
                    mem[b][w_req_addr[b*AW +: AW]] <= w_req_data[b*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rv <= '0;
            wv <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                rid[i]   <= '0;
                rmask[i] <= '0;
                rdat[i]  <= '0;
                wid[i]   <= '0;
                wmask[i] <= '0;
            end
        end else if (!res_stall) begin
            rv[0]    <= r_req_valid;
            rid[0]   <= r_req_valid ? r_req_id : '0;
            rmask[0] <= r_req_valid ? r_req_mask : '0;
            rdat[0]  <= r_req_valid ? rd : '0;
            wv[0]    <= w_req_valid;
            wid[0]   <= w_req_valid ? w_req_id : '0;
            wmask[0] <= w_req_valid ? w_req_mask : '0;
            for (int i = 1; i < READ_LAT; i++) begin
                rv[i]    <= rv[i-1];
                rid[i]   <= rid[i-1];
                rmask[i] <= rmask[i-1];
                rdat[i]  <= rdat[i-1];
                wv[i]    <= wv[i-1];
                wid[i]   <= wid[i-1];
                wmask[i] <= wmask[i-1];
            end
        end
    end

    assign r_res_valid = rv[READ_LAT-1];
    assign r_res_id    = rid[READ_LAT-1];
    assign r_res_mask  = rmask[READ_LAT-1];
    assign r_res_data  = rdat[READ_LAT-1];
    assign w_res_valid = wv[READ_LAT-1];
    assign w_res_id    = wid[READ_LAT-1];
    assign w_res_mask  = wmask[READ_LAT-1];

endmodule

// File: tb/tb_scpad_sram_responder.sv
// Directed bench for scpad_sram_responder: latency, read-first,
// masking, stall freeze and mid-flight reset.
module tb_scpad_sram_responder;

    logic         clk = 0;
    logic         rst = 0;
    logic         r_req_valid;
    logic [3:0]   r_req_mask;
    logic [31:0]  r_req_addr;
    logic [1:0]   r_req_id;
    logic         w_req_valid;
    logic [3:0]   w_req_mask;
    logic [31:0]  w_req_addr;
    logic [127:0] w_req_data;
    logic [1:0]   w_req_id;
    logic         res_stall;
    logic         sram_busy;
    logic         r_res_valid;
    logic [1:0]   r_res_id;
    logic [3:0]   r_res_mask;
    logic [127:0] r_res_data;
    logic         w_res_valid;
    logic [1:0]   w_res_id;
    logic [3:0]   w_res_mask;

    int total = 0;
    int bad   = 0;

    scpad_sram_responder dut (
        .clk(clk), .rst(rst),
        .r_req_valid(r_req_valid), .r_req_mask(r_req_mask),
        .r_req_addr(r_req_addr), .r_req_id(r_req_id),
        .w_req_valid(w_req_valid), .w_req_mask(w_req_mask),
        .w_req_addr(w_req_addr), .w_req_data(w_req_data),
        .w_req_id(w_req_id), .res_stall(res_stall),
        .sram_busy(sram_busy),
        .r_res_valid(r_res_valid), .r_res_id(r_res_id),
        .r_res_mask(r_res_mask), .r_res_data(r_res_data),
        .w_res_valid(w_res_valid), .w_res_id(w_res_id),
        .w_res_mask(w_res_mask)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        r_req_valid = 0; r_req_mask = 0; r_req_addr = 0; r_req_id = 0;
        w_req_valid = 0; w_req_mask = 0; w_req_addr = 0;
        w_req_data = 0; w_req_id = 0;
    endtask

    task automatic rd_req(input logic [3:0] m, input logic [7:0] a, input logic [1:0] id);
        r_req_valid = 1; r_req_mask = m; r_req_addr = {4{a}}; r_req_id = id;
    endtask

    task automatic wr_req(input logic [3:0] m, input logic [7:0] a,
                          input logic [127:0] d, input logic [1:0] id);
        w_req_valid = 1; w_req_mask = m; w_req_addr = {4{a}};
        w_req_data = d; w_req_id = id;
    endtask

    task automatic test_reset();
        idle();
        res_stall = 0;
        step(); step();
        #3 rst = 1;
        #1;
        total++;
        if (r_res_valid !== 0 || w_res_valid !== 0) begin
            bad++; $display("FAIL reset_valid r=%b w=%b want 0 0", r_res_valid, w_res_valid);
        end
        total++;
        if (r_res_data !== 0 || r_res_mask !== 0 || r_res_id !== 0 ||
            w_res_mask !== 0 || w_res_id !== 0) begin
            bad++; $display("FAIL reset_fields data=%h want 0", r_res_data);
        end
        res_stall = 1; #1;
        total++;
        if (sram_busy !== 1) begin bad++; $display("FAIL busy_hi got %b want 1", sram_busy); end
        res_stall = 0; #1;
        total++;
        if (sram_busy !== 0) begin bad++; $display("FAIL busy_lo got %b want 0", sram_busy); end
        step();
        rst = 0;
        step();
    endtask

    task automatic test_write_read();
        wr_req(4'b1111, 8'h10, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 2'b01);
        step();
        idle();
        step();
        total++;
        if (w_res_valid !== 1 || w_res_id !== 2'b01 || w_res_mask !== 4'b1111) begin
            bad++; $display("FAIL wack v=%b id=%b m=%b want 1 01 1111", w_res_valid, w_res_id, w_res_mask);
        end
        total++;
        if (r_res_valid !== 0) begin bad++; $display("FAIL wack_no_read got %b want 0", r_res_valid); end
        step();
        total++;
        if (w_res_valid !== 0) begin bad++; $display("FAIL wack_once got %b want 0", w_res_valid); end
        rd_req(4'b1111, 8'h10, 2'b00);
        step();
        idle();
        total++;
        if (r_res_valid !== 0) begin bad++; $display("FAIL rd_early got %b want 0", r_res_valid); end
        step();
        total++;
        if (r_res_valid !== 1 || r_res_id !== 2'b00 || r_res_mask !== 4'b1111 ||
            r_res_data !== {32'hA3, 32'hA2, 32'hA1, 32'hA0}) begin
            bad++; $display("FAIL rd_data v=%b id=%b m=%b d=%h want 1 00 1111 a3a2a1a0",
                            r_res_valid, r_res_id, r_res_mask, r_res_data);
        end
        step();
    endtask

    task automatic test_read_first();
        wr_req(4'b0001, 8'h05, 128'h1111, 2'b00);
        step();
        wr_req(4'b0001, 8'h05, 128'h2222, 2'b01);
        rd_req(4'b0001, 8'h05, 2'b10);
        step();
        idle();
        step();
        total++;
        if (r_res_valid !== 1 || r_res_data !== 128'h1111 || r_res_id !== 2'b10) begin
            bad++; $display("FAIL read_first v=%b d=%h id=%b want 1 1111 10", r_res_valid, r_res_data, r_res_id);
        end
        total++;
        if (w_res_valid !== 1 || w_res_id !== 2'b01) begin
            bad++; $display("FAIL same_cycle_ack v=%b id=%b want 1 01", w_res_valid, w_res_id);
        end
        rd_req(4'b0001, 8'h05, 2'b11);
        step();
        idle();
        step();
        total++;
        if (r_res_valid !== 1 || r_res_data !== 128'h2222) begin
            bad++; $display("FAIL read_after v=%b d=%h want 1 2222", r_res_valid, r_res_data);
        end
        step();
    endtask

    task automatic test_partial();
        wr_req(4'b1111, 8'h20, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 2'b00);
        step();
        idle();
        rd_req(4'b0101, 8'h20, 2'b01);
        step();
        idle();
        step();
        total++;
        if (r_res_mask !== 4'b0101 || r_res_data !== {32'h0, 32'hB2, 32'h0, 32'hB0}) begin
            bad++; $display("FAIL partial_rd m=%b d=%h want 0101 0_b2_0_b0", r_res_mask, r_res_data);
        end
        wr_req(4'b0010, 8'h20, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 2'b00);
        step();
        idle();
        rd_req(4'b1111, 8'h20, 2'b10);
        step();
        idle();
        step();
        total++;
        if (r_res_data !== {32'hB3, 32'hB2, 32'hC1, 32'hB0}) begin
            bad++; $display("FAIL partial_wr d=%h want b3_b2_c1_b0", r_res_data);
        end
        rd_req(4'b0000, 8'h20, 2'b11);
        step();
        idle();
        step();
        total++;
        if (r_res_valid !== 1 || r_res_mask !== 0 || r_res_data !== 0 || r_res_id !== 2'b11) begin
            bad++; $display("FAIL empty_req v=%b m=%b d=%h want 1 0 0", r_res_valid, r_res_mask, r_res_data);
        end
        step();
    endtask

    task automatic test_back_to_back();
        wr_req(4'b0001, 8'h30, 128'h5555, 2'b00);
        step();
        idle();
        rd_req(4'b0001, 8'h10, 2'd0);
        step();
        rd_req(4'b0010, 8'h10, 2'd1);
        step();
        total++;
        if (r_res_valid !== 1 || r_res_id !== 2'd0 || r_res_data !== 128'hA0) begin
            bad++; $display("FAIL b2b_id0 v=%b id=%0d d=%h want 1 0 a0", r_res_valid, r_res_id, r_res_data);
        end
        res_stall = 1;
        rd_req(4'b0100, 8'h10, 2'd2);
        wr_req(4'b0001, 8'h30, 128'hDEAD, 2'b10);
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (r_res_valid !== 1 || r_res_id !== 2'd0 || r_res_data !== 128'hA0 ||
                sram_busy !== 1 || w_res_valid !== 0) begin
                bad++; $display("FAIL stall_hold%0d v=%b id=%0d busy=%b wv=%b want 1 0 1 0",
                                i, r_res_valid, r_res_id, sram_busy, w_res_valid);
            end
        end
        w_req_valid = 0; w_req_mask = 0;
        res_stall = 0;
        step();
        total++;
        if (r_res_valid !== 1 || r_res_id !== 2'd1 || r_res_data !== {32'h0, 32'h0, 32'hA1, 32'h0}) begin
            bad++; $display("FAIL b2b_id1 v=%b id=%0d d=%h want 1 1 a1<<32", r_res_valid, r_res_id, r_res_data);
        end
        rd_req(4'b1000, 8'h10, 2'd3);
        step();
        idle();
        total++;
        if (r_res_valid !== 1 || r_res_id !== 2'd2 || r_res_mask !== 4'b0100) begin
            bad++; $display("FAIL b2b_id2 v=%b id=%0d m=%b want 1 2 0100", r_res_valid, r_res_id, r_res_mask);
        end
        step();
        total++;
        if (r_res_valid !== 1 || r_res_id !== 2'd3 || r_res_mask !== 4'b1000) begin
            bad++; $display("FAIL b2b_id3 v=%b id=%0d m=%b want 1 3 1000", r_res_valid, r_res_id, r_res_mask);
        end
        step();
        total++;
        if (r_res_valid !== 0 || w_res_valid !== 0) begin
            bad++; $display("FAIL b2b_drain r=%b w=%b want 0 0", r_res_valid, w_res_valid);
        end
        rd_req(4'b0001, 8'h30, 2'd1);
        step();
        idle();
        step();
        total++;
        if (r_res_data !== 128'h5555) begin
            bad++; $display("FAIL stall_nowrite d=%h want 5555", r_res_data);
        end
        step();
    endtask

    task automatic test_reset_midflight();
        rd_req(4'b1111, 8'h10, 2'd1);
        step();
        rd_req(4'b1111, 8'h20, 2'd2);
        step();
        idle();
        rst = 1;
        #1;
        total++;
        if (r_res_valid !== 0 || r_res_data !== 0) begin
            bad++; $display("FAIL mid_rst_now v=%b d=%h want 0 0", r_res_valid, r_res_data);
        end
        step(); step();
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (r_res_valid !== 0) begin
                bad++; $display("FAIL mid_rst_drop%0d got %b want 0", i, r_res_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_read_first();
        test_partial();
        test_back_to_back();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
